// File: rtl/shift_register.sv
// Serial-in, parallel-out shift register with shift enable.
// Entry end selectable; q is driven straight from the register.
module shift_register #(
  parameter int                 WIDTH       = 8,
  parameter bit                 MSB_IN      = 1'b0,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             shift,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_next;

  // A one-bit register has no direction: it simply loads din.
  generate
    if (WIDTH == 1) begin : g_w1
      assign r_next = din;
    end else if (MSB_IN) begin : g_msb
      assign r_next = {din, r[WIDTH-1:1]};
    end else begin : g_lsb
      assign r_next = {r[WIDTH-2:0], din};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= RESET_VALUE;
    end else if (shift) begin
      r <= r_next;
    end
  end

  assign q = r;

endmodule

// File: tb/tb_shift_register.sv
// Bench for shift_register: directed plan plus random traffic,
// checked against an arithmetic model of three configurations.
module tb_shift_register;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       shift;
  logic [7:0] q_lsb;
  logic [7:0] q_msb;
  logic [0:0] q_w1;

  int tests = 0;
  int fails = 0;

  // Model state as plain integers.
  int m_lsb;
  int m_msb;
  int m_w1;

  always #5 clk = ~clk;

  shift_register #(.WIDTH(8), .MSB_IN(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .shift(shift), .q(q_lsb)
  );

  shift_register #(.WIDTH(8), .MSB_IN(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .shift(shift), .q(q_msb)
  );

  shift_register #(.WIDTH(1), .MSB_IN(1'b0)) dut_w1 (
    .clk(clk), .rst(rst), .din(din), .shift(shift), .q(q_w1)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, need %h", tag, obs, exp);
    end
  endtask

  // Drive at a negedge, take one rising edge, check at the next negedge.
  task automatic step(input logic r, input logic s, input logic d);
    int b;
    rst   = r;
    shift = s;
    din   = d;
    @(posedge clk);
    b = d ? 1 : 0;
    if (r) begin
      m_lsb = 0;
      m_msb = 0;
      m_w1  = 0;
    end else if (s) begin
      m_lsb = (m_lsb * 2 + b) % 256;
      m_msb = m_msb / 2 + b * 128;
      m_w1  = b;
    end
    @(negedge clk);
    chk("model_lsb", q_lsb, 8'(m_lsb));
    chk("model_msb", q_msb, 8'(m_msb));
    chk("model_w1", {7'd0, q_w1}, 8'(m_w1));
  endtask

  initial begin
    logic [7:0] load_exp [8];
    logic [7:0] load_bits;
    logic [7:0] pat;
    logic [7:0] msb_exp [3];
    logic [2:0] msb_bits;

    load_exp  = '{8'h01, 8'h02, 8'h05, 8'h0B,
                  8'h16, 8'h2C, 8'h59, 8'hB2};
    load_bits = 8'b1011_0010;
    pat       = 8'h5A;
    msb_exp   = '{8'h80, 8'hC0, 8'h60};
    msb_bits  = 3'b110;
    m_lsb = 0;
    m_msb = 0;
    m_w1  = 0;
    rst   = 1'b0;
    shift = 1'b0;
    din   = 1'b0;
    @(negedge clk);

    // Reset beats shift on the same edge.
    step(1'b1, 1'b1, 1'b1);
    chk("reset", q_lsb, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'(i % 2));
      chk("reset_hold", q_lsb, 8'h00);
    end

    // Serial load 1,0,1,1,0,0,1,0.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, load_bits[7-i]);
      chk("load", q_lsb, load_exp[i]);
    end

    // Hold, then one shift drops the old MSB.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'(i % 2));
      chk("hold", q_lsb, 8'hB2);
    end
    step(1'b0, 1'b1, 1'b1);
    chk("hold_shift", q_lsb, 8'h65);

    // Overflow: nine ones, then a zero.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1);
    chk("overflow", q_lsb, 8'hFF);
    step(1'b0, 1'b1, 1'b0);
    chk("overflow_zero", q_lsb, 8'hFE);

    // Reset priority mid-stream from 5A.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, pat[7-i]);
    chk("pattern", q_lsb, 8'h5A);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_prio", q_lsb, 8'h00);
    chk("rst_prio_msb", q_msb, 8'h00);
    step(1'b0, 1'b1, 1'b1);
    chk("after_rst", q_lsb, 8'h01);

    // MSB-entry configuration.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, msb_bits[2-i]);
      chk("msb_in", q_msb, msb_exp[i]);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 16) == 0,
           1'($urandom % 2),
           1'($urandom % 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
